traffic_monitor: RTL and testbench

- Observer for one approach of the intersection. It sits on the car-lamp and walker-lamp buses driven by a traffic controller instance, and there is one monitor per approach.
- It decodes the one-hot lamp codes, tracks the car phase sequence with an FSM, and measures each phase's duration.
- It raises a sticky fault with a cause code on an illegal code, a car/walker conflict, an out-of-order phase, or a wrong phase length.
- It also counts completed signal cycles.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/lamp_decoder.sv | 27 ++
 rtl/traffic_monitor.sv | 169 ++++++++++++++++
 tb/tb_traffic_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Lamp codes, phase lengths, phase and fault enums shared by the traffic controller and its monitors.
// Pure definitions; no logic, no latency.
package traffic_pkg;

    localparam logic [3:0] C_RED    = 4'b1000;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_NONE   = 4'b0000;

    localparam logic [1:0] W_RED    = 2'b10;
    localparam logic [1:0] W_GREEN  = 2'b01;
    localparam logic [1:0] W_NONE   = 2'b00;

    localparam int GREEN_LEN = 20;
    localparam int YEL_LEN   = 2;
    localparam int LEFT_LEN  = 10;
    localparam int RED_LEN   = 34;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_GREEN   = 3'd1,
        PH_YEL1    = 3'd2,
        PH_LEFT    = 3'd3,
        PH_YEL2    = 3'd4,
        PH_RED     = 3'd5,
        PH_YEL_ANY = 3'd6
    } phase_e;

    typedef enum logic [2:0] {
        F_NONE      = 3'd0,
        F_ILLEGAL   = 3'd1,
        F_CONFLICT  = 3'd2,
        F_BAD_ORDER = 3'd3,
        F_BAD_LEN   = 3'd4
    } fault_e;

endpackage

// File: rtl/lamp_decoder.sv
// Combinational lamp decoder: car code to observed phase (yellow is ambiguous, so PH_YEL_ANY), plus illegal flags.
// Zero latency, no flow control.
module lamp_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] car_i,
    input  logic [1:0] walker_i,
    output phase_e     phase_o,
    output logic       car_illegal_o,
    output logic       walker_illegal_o
);

    always_comb begin
        phase_o       = PH_IDLE;
        car_illegal_o = 1'b0;
        case (car_i)
            C_RED:    phase_o = PH_RED;
            C_YELLOW: phase_o = PH_YEL_ANY;
            C_LEFT:   phase_o = PH_LEFT;
            C_GREEN:  phase_o = PH_GREEN;
            default:  car_illegal_o = 1'b1;
        endcase
    end

    assign walker_illegal_o = (walker_i == 2'b11);

endmodule

// File: rtl/traffic_monitor.sv
// Per-approach lamp observer: phase FSM, duration check, sticky fault with cause code, cycle counter.
// All outputs registered (fault visible one cycle after the offending sample); passive, never backpressures.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int P_GREEN_LEN = GREEN_LEN,
    parameter int P_YEL_LEN   = YEL_LEN,
    parameter int P_LEFT_LEN  = LEFT_LEN,
    parameter int P_RED_LEN   = RED_LEN,
    parameter int P_CNT_W     = 7
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [3:0] i_car_traffic,
    input  logic [1:0] i_walker_traffic,
    input  logic       i_clr_fault,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [2:0] o_phase,
    output logic       o_synced,
    output logic [7:0] o_cycle_cnt
);

    phase_e               state_q, state_d, obs, nxt;
    fault_e               code_q, code_d, new_code;
    logic [P_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 synced_q, synced_d;
    logic                 len_done_q, len_done_d;
    logic                 fault_q, fault_d;
    logic [7:0]           cyc_q, cyc_d;
    logic                 car_illegal, walker_illegal, legal;
    logic                 det_ill, det_conf, det_order, det_len;

    lamp_decoder u_dec (
        .car_i            (i_car_traffic),
        .walker_i         (i_walker_traffic),
        .phase_o          (obs),
        .car_illegal_o    (car_illegal),
        .walker_illegal_o (walker_illegal)
    );

    function automatic logic [P_CNT_W-1:0] phase_len(input phase_e ph);
        case (ph)
            PH_GREEN:         return P_CNT_W'(P_GREEN_LEN);
            PH_YEL1, PH_YEL2: return P_CNT_W'(P_YEL_LEN);
            PH_LEFT:          return P_CNT_W'(P_LEFT_LEN);
            PH_RED:           return P_CNT_W'(P_RED_LEN);
            default:          return '0;
        endcase
    endfunction

    // All three yellow states show the same lamp code.
    function automatic phase_e lamp_kind(input phase_e ph);
        if (ph == PH_YEL1 || ph == PH_YEL2 || ph == PH_YEL_ANY) return PH_YEL_ANY;
        return ph;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        synced_d   = synced_q;
        len_done_d = len_done_q;
        cyc_d      = cyc_q;
        nxt        = PH_IDLE;
        legal      = 1'b0;
        det_ill    = 1'b0;
        det_conf   = 1'b0;
        det_order  = 1'b0;
        det_len    = 1'b0;

        case (state_q)
            PH_GREEN:   begin legal = (obs == PH_YEL_ANY); nxt = PH_YEL1; end
            PH_YEL1:    begin legal = (obs == PH_LEFT);    nxt = PH_LEFT; end
            PH_LEFT:    begin legal = (obs == PH_YEL_ANY); nxt = PH_YEL2; end
            PH_YEL2:    begin legal = (obs == PH_RED);     nxt = PH_RED;  end
            PH_RED:     begin legal = (obs == PH_GREEN);   nxt = PH_GREEN; end
            PH_YEL_ANY: begin
                legal = (obs == PH_LEFT) || (obs == PH_RED);
                nxt   = obs;
            end
            default: ;
        endcase

        if (!i_start) begin
            state_d    = PH_IDLE;
            cnt_d      = '0;
            synced_d   = 1'b0;
            len_done_d = 1'b0;
        end else begin
            det_ill  = car_illegal || walker_illegal;
            det_conf = (i_car_traffic != C_RED) &&
                       (i_walker_traffic == W_GREEN || i_walker_traffic == W_NONE);
            if (!car_illegal) begin
                if (state_q == PH_IDLE) begin
                    state_d    = obs;
                    synced_d   = 1'b0;
                    cnt_d      = P_CNT_W'(1);
                    len_done_d = 1'b0;
                end else if (lamp_kind(state_q) == obs) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // An overrun is reported once; the later exit must not report it again.
                    if (synced_q && !len_done_q && cnt_q == phase_len(state_q)) begin
                        det_len    = 1'b1;
                        len_done_d = 1'b1;
                    end
                end else if (legal) begin
                    det_len    = synced_q && !len_done_q && (cnt_q != phase_len(state_q));
                    state_d    = nxt;
                    synced_d   = 1'b1;
                    cnt_d      = P_CNT_W'(1);
                    len_done_d = 1'b0;
                    if (state_q == PH_RED && cyc_q != 8'hFF) cyc_d = cyc_q + 8'd1;
                end else begin
                    det_order  = 1'b1;
                    state_d    = obs;
                    synced_d   = 1'b0;
                    cnt_d      = P_CNT_W'(1);
                    len_done_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (det_ill)        new_code = F_ILLEGAL;
        else if (det_conf)  new_code = F_CONFLICT;
        else if (det_order) new_code = F_BAD_ORDER;
        else if (det_len)   new_code = F_BAD_LEN;
        else                new_code = F_NONE;

        fault_d = fault_q;
        code_d  = code_q;
        if (new_code != F_NONE && (!fault_q || i_clr_fault)) begin
            fault_d = 1'b1;
            code_d  = new_code;
        end else if (i_clr_fault) begin
            fault_d = 1'b0;
            code_d  = F_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PH_IDLE;
            cnt_q      <= '0;
            synced_q   <= 1'b0;
            len_done_q <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= F_NONE;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            synced_q   <= synced_d;
            len_done_q <= len_done_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            cyc_q      <= cyc_d;
        end
    end

    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_phase      = state_q;
    assign o_synced     = synced_q;
    assign o_cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: legal cycles, each fault cause, clear, start drop, async reset.
module tb_traffic_monitor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic [3:0] i_car_traffic;
    logic [1:0] i_walker_traffic;
    logic       i_clr_fault;
    logic       o_fault;
    logic [2:0] o_fault_code;
    logic [2:0] o_phase;
    logic       o_synced;
    logic [7:0] o_cycle_cnt;

    int total = 0;
    int bad   = 0;

    traffic_monitor dut (
        .clk              (clk),
        .reset            (reset),
        .i_start          (i_start),
        .i_car_traffic    (i_car_traffic),
        .i_walker_traffic (i_walker_traffic),
        .i_clr_fault      (i_clr_fault),
        .o_fault          (o_fault),
        .o_fault_code     (o_fault_code),
        .o_phase          (o_phase),
        .o_synced         (o_synced),
        .o_cycle_cnt      (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] car, input logic [1:0] walk);
        i_car_traffic    = car;
        i_walker_traffic = walk;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] car, input logic [1:0] walk, input int n);
        for (int k = 0; k < n; k++) step(car, walk);
    endtask

    task automatic reset_dut();
        reset = 1'b1; i_start = 1'b0; i_clr_fault = 1'b0;
        i_car_traffic = C_NONE; i_walker_traffic = W_NONE;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b1;
    endtask

    task automatic red_phase();
        hold(C_RED, W_GREEN, 14);
        hold(C_RED, W_NONE, 6);
        hold(C_RED, W_RED, 14);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_start = 1'b0; i_clr_fault = 1'b0;
        i_car_traffic = C_NONE; i_walker_traffic = W_NONE;
        #1;
        total++;
        if ({o_fault, o_fault_code, o_phase, o_synced, o_cycle_cnt} !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got fault=%0b code=%0d phase=%0d synced=%0b cyc=%0d want all 0",
                     o_fault, o_fault_code, o_phase, o_synced, o_cycle_cnt);
        end
    endtask

    task automatic test_clean_cycles();
        reset_dut();
        step(C_GREEN, W_RED);
        total++;
        if (o_phase !== 3'd1 || o_synced !== 1'b0) begin
            bad++; $display("FAIL clean_entry phase=%0d synced=%0b want 1/0", o_phase, o_synced);
        end
        hold(C_GREEN, W_RED, 19);
        step(C_YELLOW, W_RED);
        total++;
        if (o_phase !== 3'd2 || o_synced !== 1'b1 || o_fault !== 1'b0) begin
            bad++; $display("FAIL clean_yel1 phase=%0d synced=%0b fault=%0b want 2/1/0", o_phase, o_synced, o_fault);
        end
        step(C_YELLOW, W_RED);
        hold(C_LEFT, W_RED, 10);
        total++;
        if (o_phase !== 3'd3) begin
            bad++; $display("FAIL clean_left phase=%0d want 3", o_phase);
        end
        hold(C_YELLOW, W_RED, 2);
        total++;
        if (o_phase !== 3'd4) begin
            bad++; $display("FAIL clean_yel2 phase=%0d want 4", o_phase);
        end
        red_phase();
        total++;
        if (o_phase !== 3'd5 || o_synced !== 1'b1 || o_fault !== 1'b0) begin
            bad++; $display("FAIL clean_red phase=%0d synced=%0b fault=%0b want 5/1/0", o_phase, o_synced, o_fault);
        end
        step(C_GREEN, W_RED);
        total++;
        if (o_cycle_cnt !== 8'd1 || o_phase !== 3'd1 || o_synced !== 1'b1) begin
            bad++; $display("FAIL clean_cycle1 cyc=%0d phase=%0d synced=%0b want 1/1/1", o_cycle_cnt, o_phase, o_synced);
        end
        hold(C_GREEN, W_RED, 19);
        hold(C_YELLOW, W_RED, 2);
        hold(C_LEFT, W_RED, 10);
        hold(C_YELLOW, W_RED, 2);
        red_phase();
        step(C_GREEN, W_RED);
        total++;
        if (o_cycle_cnt !== 8'd2 || o_fault !== 1'b0 || o_fault_code !== 3'd0) begin
            bad++; $display("FAIL clean_cycle2 cyc=%0d fault=%0b code=%0d want 2/0/0", o_cycle_cnt, o_fault, o_fault_code);
        end
    endtask

    // Continues from a synced GREEN with one sample already taken.
    task automatic test_bad_len();
        hold(C_GREEN, W_RED, 18);
        total++;
        if (o_fault !== 1'b0) begin
            bad++; $display("FAIL short_green_pre fault=%0b want 0", o_fault);
        end
        step(C_YELLOW, W_RED);
        total++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd4) begin
            bad++; $display("FAIL short_green fault=%0b code=%0d want 1/4", o_fault, o_fault_code);
        end
    endtask

    task automatic test_overrun();
        reset_dut();
        step(C_RED, W_RED);
        step(C_GREEN, W_RED);
        hold(C_GREEN, W_RED, 19);
        total++;
        if (o_fault !== 1'b0 || o_cycle_cnt !== 8'd1) begin
            bad++; $display("FAIL overrun_pre fault=%0b cyc=%0d want 0/1", o_fault, o_cycle_cnt);
        end
        step(C_GREEN, W_RED);
        total++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd4) begin
            bad++; $display("FAIL overrun fault=%0b code=%0d want 1/4", o_fault, o_fault_code);
        end
        i_clr_fault = 1'b1;
        step(C_GREEN, W_RED);
        i_clr_fault = 1'b0;
        step(C_YELLOW, W_RED);
        total++;
        if (o_fault !== 1'b0 || o_phase !== 3'd2) begin
            bad++; $display("FAIL overrun_exit fault=%0b phase=%0d want 0/2", o_fault, o_phase);
        end
    endtask

    task automatic test_conflict();
        reset_dut();
        hold(C_LEFT, W_RED, 3);
        total++;
        if (o_phase !== 3'd3 || o_synced !== 1'b0 || o_fault !== 1'b0) begin
            bad++; $display("FAIL conflict_pre phase=%0d synced=%0b fault=%0b want 3/0/0", o_phase, o_synced, o_fault);
        end
        step(C_LEFT, W_GREEN);
        total++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd2) begin
            bad++; $display("FAIL conflict fault=%0b code=%0d want 1/2", o_fault, o_fault_code);
        end
        step(4'b0011, W_RED);
        total++;
        if (o_fault_code !== 3'd2) begin
            bad++; $display("FAIL sticky_code code=%0d want 2", o_fault_code);
        end
    endtask

    task automatic test_illegal_clear();
        reset_dut();
        hold(C_RED, W_RED, 3);
        step(4'b0011, W_RED);
        total++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd1 || o_phase !== 3'd5) begin
            bad++; $display("FAIL illegal_car fault=%0b code=%0d phase=%0d want 1/1/5", o_fault, o_fault_code, o_phase);
        end
        i_clr_fault = 1'b1;
        step(C_RED, W_RED);
        i_clr_fault = 1'b0;
        total++;
        if (o_fault !== 1'b0 || o_fault_code !== 3'd0) begin
            bad++; $display("FAIL clear fault=%0b code=%0d want 0/0", o_fault, o_fault_code);
        end
        step(4'b0011, W_GREEN);
        total++;
        if (o_fault_code !== 3'd1) begin
            bad++; $display("FAIL priority code=%0d want 1", o_fault_code);
        end
        i_clr_fault = 1'b1;
        step(C_GREEN, W_GREEN);
        i_clr_fault = 1'b0;
        total++;
        if (o_fault !== 1'b1 || o_fault_code !== 3'd2 || o_cycle_cnt !== 8'd1) begin
            bad++; $display("FAIL clear_vs_new fault=%0b code=%0d cyc=%0d want 1/2/1", o_fault, o_fault_code, o_cycle_cnt);
        end
    endtask

    task automatic test_bad_order();
        reset_dut();
        hold(C_GREEN, W_RED, 5);
        step(C_LEFT, W_RED);
        total++;
        if (o_fault_code !== 3'd3 || o_phase !== 3'd3 || o_synced !== 1'b0) begin
            bad++; $display("FAIL bad_order code=%0d phase=%0d synced=%0b want 3/3/0", o_fault_code, o_phase, o_synced);
        end
        hold(C_LEFT, W_RED, 2);
        i_clr_fault = 1'b1;
        step(C_LEFT, W_RED);
        i_clr_fault = 1'b0;
        step(C_YELLOW, W_RED);
        total++;
        if (o_fault !== 1'b0 || o_phase !== 3'd4 || o_synced !== 1'b1) begin
            bad++; $display("FAIL resync_exit fault=%0b phase=%0d synced=%0b want 0/4/1", o_fault, o_phase, o_synced);
        end
        step(C_YELLOW, W_RED);
        step(C_RED, W_RED);
        total++;
        if (o_fault !== 1'b0 || o_phase !== 3'd5) begin
            bad++; $display("FAIL yel2_exit fault=%0b phase=%0d want 0/5", o_fault, o_phase);
        end
    endtask

    task automatic test_start_drop();
        reset_dut();
        hold(C_LEFT, W_RED, 3);
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(C_NONE, W_NONE);
            total++;
            if (o_phase !== 3'd0 || o_synced !== 1'b0 || o_fault !== 1'b0) begin
                bad++; $display("FAIL start_drop[%0d] phase=%0d synced=%0b fault=%0b want 0/0/0", k, o_phase, o_synced, o_fault);
            end
        end
        i_start = 1'b1;
        step(C_LEFT, W_RED);
        total++;
        if (o_phase !== 3'd3 || o_synced !== 1'b0 || o_fault !== 1'b0) begin
            bad++; $display("FAIL resume phase=%0d synced=%0b fault=%0b want 3/0/0", o_phase, o_synced, o_fault);
        end
    endtask

    // Continues from the resumed LEFT of test_start_drop.
    task automatic test_async_reset();
        hold(C_YELLOW, W_RED, 2);
        hold(C_RED, W_RED, 3);
        step(4'b1111, W_RED);
        total++;
        if (o_phase !== 3'd5 || o_fault !== 1'b1 || o_fault_code !== 3'd1) begin
            bad++; $display("FAIL pre_reset phase=%0d fault=%0b code=%0d want 5/1/1", o_phase, o_fault, o_fault_code);
        end
        i_car_traffic = C_RED;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({o_fault, o_fault_code, o_phase, o_synced, o_cycle_cnt} !== 16'h0) begin
            bad++; $display("FAIL async_reset fault=%0b code=%0d phase=%0d synced=%0b cyc=%0d want all 0",
                            o_fault, o_fault_code, o_phase, o_synced, o_cycle_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (o_phase !== 3'd0 || o_fault !== 1'b0) begin
                bad++; $display("FAIL reset_hold[%0d] phase=%0d fault=%0b want 0/0", k, o_phase, o_fault);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_cycle_sat();
        reset_dut();
        for (int k = 0; k < 260; k++) begin
            step(C_RED, W_RED);
            step(C_GREEN, W_RED);
            if (k == 9) begin
                total++;
                if (o_cycle_cnt !== 8'd10) begin
                    bad++; $display("FAIL cycle_count cyc=%0d want 10", o_cycle_cnt);
                end
            end
        end
        total++;
        if (o_cycle_cnt !== 8'd255) begin
            bad++; $display("FAIL cycle_sat cyc=%0d want 255", o_cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_cycles();
        test_bad_len();
        test_overrun();
        test_conflict();
        test_illegal_clear();
        test_bad_order();
        test_start_drop();
        test_async_reset();
        test_cycle_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
